// File: rtl/hps_ext_initiator_if.sv
// EXT_BUS word-protocol signals between an hps_ext initiator (master) and responder (slave).
`timescale 1ns/1ps
interface hps_ext_initiator_if;
  logic        ext_enable;
  logic        ext_strobe;
  logic [15:0] ext_din;
  logic [15:0] ext_dout;
  logic        ext_dout_en;

  modport master (output ext_enable, ext_strobe, ext_din, input ext_dout, ext_dout_en);
  modport slave  (input ext_enable, ext_strobe, ext_din, output ext_dout, ext_dout_en);
endinterface

// File: rtl/hps_ext_initiator.sv
// Initiator end of the HPS EXT_BUS word protocol: replays cmd + payload words, captures responses.
// Optional HPS_EXT_NAK_ABORT_EN: skip payload strobes when the cmd strobe is not acknowledged.
`timescale 1ns/1ps
module hps_ext_initiator #(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_GAP  = 1,
  parameter int unsigned RELEASE_CYC = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_cmd,
  input  logic [4:0]  req_len,
  input  logic        pl_wr,
  input  logic [4:0]  pl_addr,
  input  logic [15:0] pl_data,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        resp_ack,
  output logic [7:0]  resp_rise,
  hps_ext_initiator_if.master ext
);

`ifdef HPS_EXT_NAK_ABORT_EN
  localparam bit NAK_ABORT = 1'b1;
`else
  localparam bit NAK_ABORT = 1'b0;
`endif

  localparam int unsigned CNT_MAX_SG = (SETUP_CYC > STROBE_GAP) ? SETUP_CYC : STROBE_GAP;
  localparam int unsigned CNT_MAX    = (CNT_MAX_SG > RELEASE_CYC) ? CNT_MAX_SG : RELEASE_CYC;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, GAP, RELEASE} state_t;

  state_t             state;
  logic [15:0]        payload [31];
  logic [15:0]        result  [32];
  logic [15:0]        cmd_q;
  logic [4:0]         len_q;
  logic [4:0]         w;
  logic [CNT_W-1:0]   cnt;
  logic               gap_first;

  logic               accept_c;
  logic               capture_c;
  logic               ack_now_c;
  logic               last_word_c;
  logic [7:0]         rise_now_c;

  assign accept_c    = (state == IDLE) && req_valid && req_ready;
  assign capture_c   = (state == GAP) && gap_first;
  // dout_en of the cmd strobe, whether it is being captured now or already was
  assign ack_now_c   = gap_first ? ext.ext_dout_en : resp_ack;
  assign last_word_c = (w == len_q) || (NAK_ABORT && (w == 5'd0) && !ack_now_c);
  assign rise_now_c  = (capture_c && (w == 5'd0)) ? ext.ext_dout[7:0] : result[0][7:0];
  assign rd_data     = result[rd_addr];

  // Payload is writable only while idle so it stays stable during a transaction
  always_ff @(posedge clk_sys) begin
    if (pl_wr && (state == IDLE) && (pl_addr != 5'd31)) begin
      payload[pl_addr] <= pl_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (capture_c && !reset) begin
      result[w] <= ext.ext_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      resp_ack       <= 1'b0;
      resp_rise      <= 8'h00;
      ext.ext_enable <= 1'b0;
      ext.ext_strobe <= 1'b0;
      ext.ext_din    <= 16'h0000;
      cmd_q          <= 16'h0000;
      len_q          <= 5'd0;
      w              <= 5'd0;
      cnt            <= '0;
      gap_first      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            cmd_q          <= req_cmd;
            len_q          <= req_len;
            w              <= 5'd0;
            cnt            <= CNT_W'(SETUP_CYC - 1);
            req_ready      <= 1'b0;
            busy           <= 1'b1;
            resp_ack       <= 1'b0;
            ext.ext_enable <= 1'b1;
            state          <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            ext.ext_strobe <= 1'b1;
            ext.ext_din    <= cmd_q;
            state          <= STROBE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        STROBE: begin
          ext.ext_strobe <= 1'b0;
          cnt            <= CNT_W'(STROBE_GAP - 1);
          gap_first      <= 1'b1;
          state          <= GAP;
        end
        GAP: begin
          gap_first <= 1'b0;
          if (capture_c && (w == 5'd0)) begin
            resp_ack <= ext.ext_dout_en;
          end
          if (cnt == '0) begin
            if (last_word_c) begin
              ext.ext_enable <= 1'b0;
              ext.ext_din    <= 16'h0000;
              done           <= 1'b1;
              resp_rise      <= rise_now_c;
              cnt            <= CNT_W'(RELEASE_CYC - 1);
              state          <= RELEASE;
            end else begin
              // payload[w] is word w+1 of the transaction
              w              <= w + 5'd1;
              ext.ext_strobe <= 1'b1;
              ext.ext_din    <= payload[w];
              state          <= STROBE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt == '0) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hps_ext_initiator.sv
// Scoreboard bench for hps_ext_initiator driving a behavioural hps_ext-style responder.
`timescale 1ns/1ps
module tb_hps_ext_initiator;
  localparam int unsigned SETUP_CYC   = 1;
  localparam int unsigned STROBE_GAP  = 1;
  localparam int unsigned RELEASE_CYC = 2;
`ifdef HPS_EXT_NAK_ABORT_EN
  localparam bit NAK_ABORT = 1'b1;
`else
  localparam bit NAK_ABORT = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_cmd = 16'h0;
  logic [4:0]  req_len = 5'd0;
  logic        pl_wr = 1'b0;
  logic [4:0]  pl_addr = 5'd0;
  logic [15:0] pl_data = 16'h0;
  logic [4:0]  rd_addr = 5'd0;
  logic [15:0] rd_data;
  logic        busy, done, resp_ack;
  logic [7:0]  resp_rise;

  hps_ext_initiator_if ext();

  hps_ext_initiator #(.SETUP_CYC(SETUP_CYC), .STROBE_GAP(STROBE_GAP), .RELEASE_CYC(RELEASE_CYC)) dut (
    .clk_sys(clk_sys), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_len(req_len), .pl_wr(pl_wr), .pl_addr(pl_addr), .pl_data(pl_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .resp_ack(resp_ack),
    .resp_rise(resp_rise), .ext(ext)
  );

  always #5 clk_sys = ~clk_sys;

  // Responder: acks cmds 'hf0..'hf7, answers the cmd strobe with its enable-rise count
  // and each payload word with (din ^ 'h5A5A) + word index; all-zero after a NAK.
  logic [4:0]  r_idx = 5'd0;
  logic        r_ack = 1'b0;
  logic        r_en_d = 1'b0;
  logic [7:0]  r_rise = 8'd0;
  logic [15:0] r_dout = 16'h0;
  logic        r_dout_en = 1'b0;
  assign ext.ext_dout    = r_dout;
  assign ext.ext_dout_en = r_dout_en;

  always @(posedge clk_sys) begin
    logic [7:0] rise_n;
    logic       ok;
    rise_n = r_rise + ((ext.ext_enable && !r_en_d) ? 8'd1 : 8'd0);
    ok     = (ext.ext_din[15:3] == 13'h001E);
    r_rise <= rise_n;
    r_en_d <= ext.ext_enable;
    if (!ext.ext_enable) begin
      r_idx     <= 5'd0;
      r_dout_en <= 1'b0;
    end else if (ext.ext_strobe) begin
      if (r_idx == 5'd0) begin
        r_ack     <= ok;
        r_dout_en <= ok;
        r_dout    <= {8'h00, rise_n};
      end else begin
        r_dout_en <= r_ack;
        r_dout    <= r_ack ? ((ext.ext_din ^ 16'h5A5A) + 16'(r_idx)) : 16'h0000;
      end
      if (r_idx != 5'd31) r_idx <= r_idx + 5'd1;
    end
  end

  typedef struct packed {
    logic                ack;
    logic [7:0]          rise;
    logic [5:0]          nstr;
    logic [31:0][15:0]   words;
    logic [31:0][15:0]   res;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passes = 0;
  int          mon_scnt = 0;
  logic [15:0] m_pl  [31];
  logic [15:0] m_res [32];
  logic [7:0]  m_rise = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: event not allowed here", name);
  endtask

  // Monitor: checks every strobe word and every completed transaction against the queue head
  initial begin
    int   bcnt;
    int   exp_total;
    exp_t cur;
    bcnt = 0;
    exp_total = 0;
    forever begin
      @(posedge clk_sys);
      #2;
      if (reset) begin
        bcnt = 0;
        mon_scnt = 0;
        continue;
      end
      check("ready_vs_busy", {31'd0, req_ready}, {31'd0, ~busy});
      if (busy) bcnt++;
      if (ext.ext_strobe) begin
        if (q.size() == 0) fail_now("unexpected_strobe");
        else if (mon_scnt < 32) begin
          cur = q[0];
          check($sformatf("din[%0d]", mon_scnt), {16'h0, ext.ext_din}, {16'h0, cur.words[mon_scnt]});
          if (mon_scnt == 0) check("first_strobe_latency", bcnt, 1 + SETUP_CYC);
        end
        mon_scnt++;
      end
      if (done) begin
        if (q.size() == 0) fail_now("unexpected_done");
        else begin
          cur = q.pop_front();
          check("resp_ack", {31'd0, resp_ack}, {31'd0, cur.ack});
          check("resp_rise", {24'd0, resp_rise}, {24'd0, cur.rise});
          check("strobe_count", mon_scnt, int'(cur.nstr));
          check("busy_at_done", bcnt, int'(SETUP_CYC) + int'(cur.nstr) * int'(1 + STROBE_GAP) + 1);
          check("enable_low_at_done", {31'd0, ext.ext_enable}, 32'd0);
          exp_total = int'(SETUP_CYC) + int'(cur.nstr) * int'(1 + STROBE_GAP) + int'(RELEASE_CYC);
          for (int k = 0; k < 32; k++) begin
            rd_addr = 5'(k);
            #0.05;
            check($sformatf("result[%0d]", k), {16'h0, rd_data}, {16'h0, cur.res[k]});
          end
        end
        mon_scnt = 0;
      end
      if (!busy && bcnt != 0) begin
        check("busy_cycles", bcnt, exp_total);
        bcnt = 0;
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 500; i++) begin
      if (req_ready) return;
      @(negedge clk_sys);
    end
    fail_now("wait_ready_timeout");
  endtask

  // Issue one request; the reference model predicts its strobes, results and timing
  task automatic issue(input logic [15:0] cmd, input logic [4:0] len, input bit hold,
                       input bit rand_pl, input bit pl_in_accept);
    exp_t        e;
    logic        ack;
    int          n;
    int          dn;
    bit          got;
    logic [15:0] v;
    if (!hold) begin
      wait_ready();
      for (int k = 0; k < int'(len); k++) begin
        v = rand_pl ? 16'($urandom) : m_pl[k];
        m_pl[k] = v;
        if (!(pl_in_accept && k == int'(len) - 1)) begin
          pl_wr = 1'b1; pl_addr = 5'(k); pl_data = v;
          @(negedge clk_sys);
        end
      end
      pl_wr = 1'b0;
      if (pl_in_accept && len != 5'd0) begin
        pl_wr = 1'b1; pl_addr = len - 5'd1; pl_data = m_pl[len - 5'd1];
      end
    end
    req_cmd = cmd; req_len = len; req_valid = 1'b1;
    dn = -1; got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (done) dn = i;
      if (req_ready) begin got = 1'b1; if (hold && dn >= 0) check("hold_accept_delay", i - dn, RELEASE_CYC); break; end
      @(negedge clk_sys);
    end
    if (!got) begin
      fail_now("accept_timeout");
      req_valid = 1'b0; pl_wr = 1'b0;
      return;
    end
    ack = (cmd[15:3] == 13'h001E);
    n = (NAK_ABORT && !ack) ? 1 : int'(len) + 1;
    m_rise = m_rise + 8'd1;
    m_res[0] = {8'h00, m_rise};
    for (int k = 1; k < n; k++) m_res[k] = ack ? ((m_pl[k-1] ^ 16'h5A5A) + 16'(k)) : 16'h0000;
    e.ack = ack; e.rise = m_rise; e.nstr = 6'(n);
    e.words = '0;
    e.words[0] = cmd;
    for (int k = 1; k <= int'(len); k++) e.words[k] = m_pl[k-1];
    for (int k = 0; k < 32; k++) e.res[k] = m_res[k];
    q.push_back(e);
    @(negedge clk_sys);
    req_valid = 1'b0;
    // Writes while busy must be ignored
    for (int g = 0; g < 2; g++) begin
      pl_wr = 1'b1; pl_addr = 5'($urandom_range(31)); pl_data = 16'($urandom);
      @(negedge clk_sys);
    end
    pl_wr = 1'b0;
  endtask

  initial begin
    logic [15:0] saved [32];
    bit          got;
    logic [15:0] c;
    logic [4:0]  l;
    for (int k = 0; k < 31; k++) m_pl[k] = 16'h0;
    repeat (3) @(negedge clk_sys);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_resp_ack", {31'd0, resp_ack}, 32'd0);
    check("rst_resp_rise", {24'd0, resp_rise}, 32'd0);
    check("rst_enable", {31'd0, ext.ext_enable}, 32'd0);
    check("rst_strobe", {31'd0, ext.ext_strobe}, 32'd0);
    check("rst_din", {16'd0, ext.ext_din}, 32'd0);
    reset = 1'b0;
    // Results are not cleared by reset; establish a known baseline
    issue(16'h00F0, 5'd31, 1'b0, 1'b1, 1'b0);

    m_pl[0] = 16'h0001;
    issue(16'h00F3, 5'd1, 1'b0, 1'b0, 1'b1);
    issue(16'h00F1, 5'd1, 1'b0, 1'b1, 1'b0);
    issue(16'h00F0, 5'd22, 1'b0, 1'b1, 1'b0);
    issue(16'h0010, 5'd2, 1'b0, 1'b1, 1'b0);
    m_pl[0] = 16'h0001; m_pl[1] = 16'hBEEF; m_pl[2] = 16'h0001;
    issue(16'h00F7, 5'd3, 1'b0, 1'b0, 1'b0);
    issue(16'h00F1, 5'd0, 1'b1, 1'b0, 1'b0);

    // Reset during the second strobe of a long transaction
    for (int k = 0; k < 32; k++) saved[k] = m_res[k];
    issue(16'h00F0, 5'd22, 1'b0, 1'b1, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ext.ext_strobe && mon_scnt == 2) begin got = 1'b1; break; end
      @(negedge clk_sys);
    end
    if (!got) fail_now("second_strobe_timeout");
    reset = 1'b1;
    void'(q.pop_back());
    for (int k = 0; k < 32; k++) m_res[k] = saved[k];
    m_res[0] = {8'h00, m_rise};
    @(negedge clk_sys);
    check("abort_enable", {31'd0, ext.ext_enable}, 32'd0);
    check("abort_strobe", {31'd0, ext.ext_strobe}, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    issue(16'h00F1, 5'd1, 1'b0, 1'b1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      c = ($urandom_range(3) != 0) ? (16'h00F0 + 16'($urandom_range(7))) : 16'($urandom);
      case ($urandom_range(3))
        0: l = 5'd0;
        1: l = 5'd31;
        default: l = 5'($urandom_range(31));
      endcase
      issue(c, l, ($urandom_range(3) == 0), 1'b1, ($urandom_range(1) == 1));
    end

    for (int i = 0; i < 2000 && (q.size() != 0 || busy); i++) @(negedge clk_sys);
    if (q.size() != 0 || busy) fail_now("drain_timeout");
    repeat (3) @(negedge clk_sys);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
